// File: rtl/avalonmem_pkg.sv
// Shared definitions for the Avalon-write/stream-read buffer and its capture-memory sibling.
package avalonmem_pkg;

  localparam int AVM_ADDR_W = 9;
  localparam int AVM_DATA_W = 32;

  // Stream engine state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Tag travelling with every issued read: source address and end-of-stream marker
  typedef struct packed {
    logic [AVM_ADDR_W-1:0] addr;
    logic                  last;
  } avm_tag_t;

endpackage

// File: rtl/avalonmem_tx_fifo.sv
// First-word-fall-through FIFO holding read data plus its tag; head is visible while count != 0.
module avalonmem_tx_fifo #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 10,
  parameter int DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      push_data_i,
  input  logic [TAG_W-1:0]       push_tag_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [DATA_W-1:0]      head_data_o,
  output logic [TAG_W-1:0]       head_tag_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push, do_pop;

  // A push into a full FIFO is accepted when the head leaves in the same cycle
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  // Entry storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      data_mem[wr_ptr_q] <= push_data_i;
      tag_mem[wr_ptr_q]  <= push_tag_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o     = (count_q != '0);
  assign head_data_o = data_mem[rd_ptr_q];
  assign head_tag_o  = tag_mem[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/avalonmem_tx.sv
// Avalon-MM write slave into a 512x32 RAM, plus a stream engine that plays a window back
// over valid/ready. RAM contents are not touched by reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for STREAM_START
// ST_RUN   | issuing one RAM read per cycle while credit remains
// ST_DRAIN | all reads issued; waiting for the last word to be accepted
module avalonmem_tx
  import avalonmem_pkg::*;
#(
  parameter int PARAM_MEM_LATENCY = 3,
  parameter int PARAM_ADDR_W      = AVM_ADDR_W,
  parameter int PARAM_DATA_W      = AVM_DATA_W,
  parameter int PARAM_FIFO_DEPTH  = 4
) (
  input  logic                      AVALON_CLK,
  input  logic                      AVALON_RESET,
  input  logic [PARAM_ADDR_W-1:0]   AVALON_ADDRESS,
  input  logic                      AVALON_CHIPSELECT,
  input  logic                      AVALON_WRITE,
  input  logic [PARAM_DATA_W-1:0]   AVALON_WRITEDATA,
  input  logic [PARAM_DATA_W/8-1:0] AVALON_BYTEENABLE,
  input  logic                      AVALON_CLKEN,
  input  logic                      STREAM_START,
  input  logic [PARAM_ADDR_W-1:0]   STREAM_BASE,
  input  logic [PARAM_ADDR_W:0]     STREAM_LEN,
  output logic                      STREAM_BUSY,
  output logic                      STREAM_DONE,
  output logic [PARAM_DATA_W-1:0]   MEM_DATA,
  output logic [PARAM_ADDR_W-1:0]   MEM_ADDR,
  output logic                      MEM_LAST,
  output logic                      MEM_VALID,
  input  logic                      MEM_READY
);

  localparam int                    BE_W       = PARAM_DATA_W / 8;
  localparam int                    MEM_DEPTH  = 2 ** PARAM_ADDR_W;
  localparam int                    CNT_W      = $clog2(PARAM_FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]        CREDIT_MAX = (CNT_W+1)'(PARAM_FIFO_DEPTH);
  localparam logic [PARAM_ADDR_W:0] LEN_ONE    = (PARAM_ADDR_W+1)'(1);

  logic [PARAM_DATA_W-1:0] ram [MEM_DEPTH];

  logic                    wr_en_q;
  logic [PARAM_ADDR_W-1:0] wr_addr_q;
  logic [PARAM_DATA_W-1:0] wr_data_q;
  logic [BE_W-1:0]         wr_be_q;

  logic [1:0]              state_q, state_d;
  logic [PARAM_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [PARAM_ADDR_W:0]   remaining_q, remaining_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        in_flight_q;
  logic [CNT_W-1:0]        fifo_count;

  logic                    issue, pop, push_vld, fifo_valid;
  avm_tag_t                issue_tag, push_tag, head_tag;
  logic [PARAM_DATA_W-1:0] push_data, head_data;

  // Register the Avalon write port once; the RAM write lands on the following edge
  always_ff @(posedge AVALON_CLK or posedge AVALON_RESET) begin
    if (AVALON_RESET) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
    end else begin
      wr_en_q   <= AVALON_CLKEN & AVALON_CHIPSELECT & AVALON_WRITE;
      wr_addr_q <= AVALON_ADDRESS;
      wr_data_q <= AVALON_WRITEDATA;
      wr_be_q   <= AVALON_BYTEENABLE;
    end
  end

  // Byte-lane RAM write
  always_ff @(posedge AVALON_CLK) begin
    if (wr_en_q) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be_q[b]) ram[wr_addr_q][b*8 +: 8] <= wr_data_q[b*8 +: 8];
      end
    end
  end

  // Issue only when every outstanding read is guaranteed a FIFO slot
  assign issue     = (state_q == ST_RUN) &&
                     (({1'b0, in_flight_q} + {1'b0, fifo_count}) < CREDIT_MAX);
  assign issue_tag = '{addr: rd_addr_q, last: (remaining_q == LEN_ONE)};

  // Read pipeline: the RAM output register is the first stage of the latency budget
  if (PARAM_MEM_LATENCY == 1) begin : g_lat1
    assign push_vld  = issue;
    assign push_tag  = issue_tag;
    assign push_data = ram[rd_addr_q];
  end else begin : g_latn
    localparam int NSTG = PARAM_MEM_LATENCY - 1;
    logic [PARAM_DATA_W-1:0] stg_data_q [NSTG];
    avm_tag_t                stg_tag_q  [NSTG];
    logic [NSTG-1:0]         stg_vld_q;

    // RAM read and data shift; a same-edge write to the read address yields the old word
    always_ff @(posedge AVALON_CLK) begin
      stg_data_q[0] <= ram[rd_addr_q];
      for (int i = 1; i < NSTG; i++) stg_data_q[i] <= stg_data_q[i-1];
    end

    // Valid/tag shift, cleared by reset so an aborted stream leaves nothing behind
    always_ff @(posedge AVALON_CLK or posedge AVALON_RESET) begin
      if (AVALON_RESET) begin
        stg_vld_q <= '0;
        for (int i = 0; i < NSTG; i++) stg_tag_q[i] <= '0;
      end else begin
        stg_vld_q[0] <= issue;
        stg_tag_q[0] <= issue_tag;
        for (int i = 1; i < NSTG; i++) begin
          stg_vld_q[i] <= stg_vld_q[i-1];
          stg_tag_q[i] <= stg_tag_q[i-1];
        end
      end
    end

    assign push_vld  = stg_vld_q[NSTG-1];
    assign push_tag  = stg_tag_q[NSTG-1];
    assign push_data = stg_data_q[NSTG-1];
  end

  avalonmem_tx_fifo #(
    .DATA_W (PARAM_DATA_W),
    .TAG_W  ($bits(avm_tag_t)),
    .DEPTH  (PARAM_FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (AVALON_CLK),
    .rst_i       (AVALON_RESET),
    .push_i      (push_vld),
    .push_data_i (push_data),
    .push_tag_i  (push_tag),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .head_data_o (head_data),
    .head_tag_o  (head_tag),
    .count_o     (fifo_count)
  );

  assign pop = fifo_valid & MEM_READY;

  // Next-state logic; START outside IDLE is ignored
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (STREAM_START) begin
          if (STREAM_LEN != '0) begin
            state_d     = ST_RUN;
            rd_addr_d   = STREAM_BASE;
            remaining_d = STREAM_LEN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          rd_addr_d   = rd_addr_q + PARAM_ADDR_W'(1);
          remaining_d = remaining_q - LEN_ONE;
          if (remaining_q == LEN_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((in_flight_q == '0) && pop && head_tag.last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, address/length counters, outstanding-read count and DONE pulse
  always_ff @(posedge AVALON_CLK or posedge AVALON_RESET) begin
    if (AVALON_RESET) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      in_flight_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      in_flight_q <= in_flight_q + CNT_W'(issue) - CNT_W'(push_vld);
    end
  end

  assign MEM_VALID   = fifo_valid;
  assign MEM_DATA    = fifo_valid ? head_data : '0;
  assign MEM_ADDR    = fifo_valid ? head_tag.addr : '0;
  assign MEM_LAST    = fifo_valid & head_tag.last;
  assign STREAM_BUSY = (state_q != ST_IDLE);
  assign STREAM_DONE = done_q;

endmodule

// File: tb/tb_avalonmem_tx.sv
// Directed bench for avalonmem_tx: Avalon writes, streamed readback, wrap, backpressure,
// zero-length and ignored starts, and reset in the middle of a stream.
module tb_avalonmem_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  av_addr;
  logic        av_cs, av_wr, av_clken;
  logic [31:0] av_wdata;
  logic [3:0]  av_be;
  logic        st_start;
  logic [8:0]  st_base;
  logic [9:0]  st_len;
  logic        st_busy, st_done;
  logic [31:0] mem_data;
  logic [8:0]  mem_addr;
  logic        mem_last, mem_valid, mem_ready;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [512];

  always #5 clk = ~clk;

  avalonmem_tx dut (
    .AVALON_CLK        (clk),
    .AVALON_RESET      (rst),
    .AVALON_ADDRESS    (av_addr),
    .AVALON_CHIPSELECT (av_cs),
    .AVALON_WRITE      (av_wr),
    .AVALON_WRITEDATA  (av_wdata),
    .AVALON_BYTEENABLE (av_be),
    .AVALON_CLKEN      (av_clken),
    .STREAM_START      (st_start),
    .STREAM_BASE       (st_base),
    .STREAM_LEN        (st_len),
    .STREAM_BUSY       (st_busy),
    .STREAM_DONE       (st_done),
    .MEM_DATA          (mem_data),
    .MEM_ADDR          (mem_addr),
    .MEM_LAST          (mem_last),
    .MEM_VALID         (mem_valid),
    .MEM_READY         (mem_ready)
  );

  task automatic avm_write(input logic [8:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic ce);
    @(posedge clk); #1;
    av_cs = 1'b1; av_wr = 1'b1; av_clken = ce; av_addr = a; av_wdata = d; av_be = be;
    @(posedge clk); #1;
    av_cs = 1'b0; av_wr = 1'b0; av_clken = 1'b1;
    if (ce) for (int b = 0; b < 4; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Returns 1 ns into cycle 1 (the cycle after the edge that samples START)
  task automatic start_stream(input logic [8:0] b, input logic [9:0] l);
    @(posedge clk); #1;
    st_start = 1'b1; st_base = b; st_len = l;
    @(posedge clk); #1;
    st_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_valid, mem_last, st_busy, st_done} !== 4'b0000 || mem_data !== 32'h0 || mem_addr !== 9'h0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b l=%b b=%b d=%b data=%h addr=%h exp all 0",
               mem_valid, mem_last, st_busy, st_done, mem_data, mem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_stream();
    int first_cyc, last_cyc, done_cyc, done_cnt, nwords;
    logic [8:0]  exp_addr;
    logic [31:0] exp_data;
    mem_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #1;
      av_cs = 1'b1; av_wr = 1'b1; av_clken = 1'b1; av_be = 4'hF;
      av_addr = 9'(i); av_wdata = 32'(i * 3);
      model[i] = 32'(i * 3);
    end
    @(posedge clk); #1;
    av_cs = 1'b0; av_wr = 1'b0;
    start_stream(9'h000, 10'd512);
    first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0; nwords = 0; exp_addr = 9'h000;
    for (int cyc = 1; cyc <= 530; cyc++) begin
      @(negedge clk);
      if (mem_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        exp_data = {23'h0, exp_addr} * 32'd3;
        total++;
        if (mem_addr !== exp_addr) begin
          bad++; $display("FAIL full_addr got=%h exp=%h", mem_addr, exp_addr);
        end
        total++;
        if (mem_data !== exp_data) begin
          bad++; $display("FAIL full_data addr=%h got=%h exp=%h", exp_addr, mem_data, exp_data);
        end
        total++;
        if (mem_last !== (exp_addr == 9'h1FF)) begin
          bad++; $display("FAIL full_last addr=%h got=%b exp=%b", exp_addr, mem_last, exp_addr == 9'h1FF);
        end
        last_cyc = cyc; nwords++; exp_addr = exp_addr + 9'd1;
      end
      if (st_done) begin done_cnt++; done_cyc = cyc; end
    end
    total++;
    if (first_cyc !== 4) begin bad++; $display("FAIL full_first_valid got=%0d exp=4", first_cyc); end
    total++;
    if (nwords !== 512) begin bad++; $display("FAIL full_word_count got=%0d exp=512", nwords); end
    total++;
    if (last_cyc !== 515) begin bad++; $display("FAIL full_no_bubbles last_cycle got=%0d exp=515", last_cyc); end
    total++;
    if (done_cnt !== 1 || done_cyc !== 516) begin
      bad++; $display("FAIL full_done got count=%0d cycle=%0d exp count=1 cycle=516", done_cnt, done_cyc);
    end
  endtask

  task automatic test_byte_enable();
    int found;
    avm_write(9'd5, 32'hAABBCCDD, 4'hF, 1'b1);
    avm_write(9'd5, 32'h11223344, 4'b0101, 1'b1);
    avm_write(9'd5, 32'hFFFFFFFF, 4'b0000, 1'b1);
    avm_write(9'd5, 32'h00000000, 4'hF, 1'b0);
    mem_ready = 1'b1;
    start_stream(9'd5, 10'd1);
    found = 0;
    for (int cyc = 1; cyc <= 10 && found == 0; cyc++) begin
      @(negedge clk);
      if (mem_valid) begin
        found = 1;
        total++;
        if (mem_data !== 32'hAA22CC44 || mem_addr !== 9'd5 || mem_last !== 1'b1) begin
          bad++;
          $display("FAIL byte_enable got data=%h addr=%h last=%b exp data=aa22cc44 addr=005 last=1",
                   mem_data, mem_addr, mem_last);
        end
      end
    end
    total++;
    if (found !== 1) begin bad++; $display("FAIL byte_enable_timeout got no word exp one word"); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read_old();
    int found;
    logic [31:0] old_word;
    old_word = model[7];
    mem_ready = 1'b1;
    @(posedge clk); #1;
    st_start = 1'b1; st_base = 9'd7; st_len = 10'd1;
    av_cs = 1'b1; av_wr = 1'b1; av_clken = 1'b1; av_addr = 9'd7; av_wdata = 32'hDEADBEEF; av_be = 4'hF;
    @(posedge clk); #1;
    st_start = 1'b0; av_cs = 1'b0; av_wr = 1'b0;
    model[7] = 32'hDEADBEEF;
    found = 0;
    for (int cyc = 1; cyc <= 10 && found == 0; cyc++) begin
      @(negedge clk);
      if (mem_valid) begin
        found = 1;
        total++;
        if (mem_data !== old_word) begin
          bad++; $display("FAIL read_old_data got=%h exp=%h", mem_data, old_word);
        end
      end
    end
    total++;
    if (found !== 1) begin bad++; $display("FAIL read_old_timeout got no word exp one word"); end
    repeat (3) @(negedge clk);
    start_stream(9'd7, 10'd1);
    found = 0;
    for (int cyc = 1; cyc <= 10 && found == 0; cyc++) begin
      @(negedge clk);
      if (mem_valid) begin
        found = 1;
        total++;
        if (mem_data !== 32'hDEADBEEF) begin
          bad++; $display("FAIL read_new_data got=%h exp=deadbeef", mem_data);
        end
      end
    end
    total++;
    if (found !== 1) begin bad++; $display("FAIL read_new_timeout got no word exp one word"); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [8:0] exp_seq [4];
    int n;
    exp_seq[0] = 9'h1FE; exp_seq[1] = 9'h1FF; exp_seq[2] = 9'h000; exp_seq[3] = 9'h001;
    mem_ready = 1'b1;
    start_stream(9'h1FE, 10'd4);
    n = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (mem_valid) begin
        if (n < 4) begin
          total++;
          if (mem_addr !== exp_seq[n] || mem_data !== model[exp_seq[n]] || mem_last !== (n == 3)) begin
            bad++;
            $display("FAIL wrap_word%0d got addr=%h data=%h last=%b exp addr=%h data=%h last=%b",
                     n, mem_addr, mem_data, mem_last, exp_seq[n], model[exp_seq[n]], n == 3);
          end
        end
        n++;
      end
    end
    total++;
    if (n !== 4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", n); end
  endtask

  task automatic test_backpressure();
    logic [8:0]  exp_addr, held_addr;
    logic [31:0] held_data;
    logic        held_last, held;
    int          nacc, ndone;
    exp_addr = 9'h040; held = 1'b0; held_addr = '0; held_data = '0; held_last = 1'b0;
    nacc = 0; ndone = 0;
    mem_ready = 1'b0;
    start_stream(9'h040, 10'd64);
    for (int cyc = 0; cyc < 2000 && ndone == 0; cyc++) begin
      @(posedge clk); #1;
      mem_ready = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      if (st_done) ndone++;
      if (mem_valid) begin
        if (held) begin
          total++;
          if (mem_data !== held_data || mem_addr !== held_addr || mem_last !== held_last) begin
            bad++;
            $display("FAIL bp_hold got addr=%h data=%h last=%b exp addr=%h data=%h last=%b",
                     mem_addr, mem_data, mem_last, held_addr, held_data, held_last);
          end
        end
        if (mem_ready) begin
          total++;
          if (mem_addr !== exp_addr || mem_data !== model[exp_addr] || mem_last !== (nacc == 63)) begin
            bad++;
            $display("FAIL bp_word%0d got addr=%h data=%h last=%b exp addr=%h data=%h last=%b",
                     nacc, mem_addr, mem_data, mem_last, exp_addr, model[exp_addr], nacc == 63);
          end
          nacc++; exp_addr = exp_addr + 9'd1; held = 1'b0;
        end else begin
          held = 1'b1; held_addr = mem_addr; held_data = mem_data; held_last = mem_last;
        end
      end else if (held) begin
        total++; bad++;
        $display("FAIL bp_valid_dropped got valid=0 exp valid=1 addr=%h", held_addr);
        held = 1'b0;
      end
    end
    total++;
    if (nacc !== 64) begin bad++; $display("FAIL bp_count got=%0d exp=64", nacc); end
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL bp_done got=%0d exp=1", ndone); end
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_len_and_busy();
    int n, ndone, busy_seen;
    logic [8:0] exp_addr;
    mem_ready = 1'b1;
    start_stream(9'h000, 10'd0);
    @(negedge clk);
    total++;
    if (st_done !== 1'b1 || st_busy !== 1'b0 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL zero_len_c1 got done=%b busy=%b valid=%b exp 1 0 0", st_done, st_busy, mem_valid);
    end
    busy_seen = 0;
    for (int cyc = 2; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (st_busy || mem_valid || st_done) busy_seen++;
    end
    total++;
    if (busy_seen !== 0) begin bad++; $display("FAIL zero_len_after got activity=%0d exp=0", busy_seen); end

    mem_ready = 1'b0;
    start_stream(9'h100, 10'd3);
    @(negedge clk);
    total++;
    if (st_busy !== 1'b1) begin bad++; $display("FAIL busy_run got=%b exp=1", st_busy); end
    @(posedge clk); #1;
    st_start = 1'b1; st_base = 9'h000; st_len = 10'd5;
    @(posedge clk); #1;
    st_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    st_start = 1'b1; st_base = 9'h010; st_len = 10'd7;
    @(posedge clk); #1;
    st_start = 1'b0;
    mem_ready = 1'b1;
    n = 0; ndone = 0; exp_addr = 9'h100;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (st_done) ndone++;
      if (mem_valid) begin
        total++;
        if (mem_addr !== exp_addr || mem_data !== model[exp_addr] || mem_last !== (n == 2)) begin
          bad++;
          $display("FAIL ignore_start_word%0d got addr=%h data=%h last=%b exp addr=%h data=%h last=%b",
                   n, mem_addr, mem_data, mem_last, exp_addr, model[exp_addr], n == 2);
        end
        n++; exp_addr = exp_addr + 9'd1;
      end
    end
    total++;
    if (n !== 3 || ndone !== 1 || st_busy !== 1'b0) begin
      bad++; $display("FAIL ignore_start got words=%0d done=%0d busy=%b exp 3 1 0", n, ndone, st_busy);
    end
  endtask

  task automatic test_reset_mid_stream();
    int nacc, hit, act, n;
    logic [8:0] exp_addr;
    mem_ready = 1'b1;
    start_stream(9'h000, 10'd100);
    nacc = 0; hit = 0;
    for (int cyc = 1; cyc <= 60 && hit == 0; cyc++) begin
      @(negedge clk);
      if (mem_valid) begin
        if (nacc == 10) begin
          hit = 1;
          rst = 1'b1;
          #1;
          total++;
          if ({mem_valid, mem_last, st_busy, st_done} !== 4'b0000 || mem_data !== 32'h0 || mem_addr !== 9'h0) begin
            bad++;
            $display("FAIL reset_mid got v=%b l=%b b=%b d=%b data=%h addr=%h exp all 0",
                     mem_valid, mem_last, st_busy, st_done, mem_data, mem_addr);
          end
        end else begin
          nacc++;
        end
      end
    end
    total++;
    if (hit !== 1) begin bad++; $display("FAIL reset_mid_timeout got words=%0d exp word 10", nacc); rst = 1'b1; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    act = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (st_done || mem_valid || st_busy) act++;
    end
    total++;
    if (act !== 0) begin bad++; $display("FAIL reset_no_done got activity=%0d exp=0", act); end
    start_stream(9'h080, 10'd2);
    n = 0; exp_addr = 9'h080;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (mem_valid) begin
        total++;
        if (mem_addr !== exp_addr || mem_data !== model[exp_addr]) begin
          bad++;
          $display("FAIL post_reset_word%0d got addr=%h data=%h exp addr=%h data=%h",
                   n, mem_addr, mem_data, exp_addr, model[exp_addr]);
        end
        n++; exp_addr = exp_addr + 9'd1;
      end
    end
    total++;
    if (n !== 2) begin bad++; $display("FAIL post_reset_count got=%0d exp=2", n); end
  endtask

  initial begin
    rst = 1'b1;
    av_addr = '0; av_cs = 1'b0; av_wr = 1'b0; av_wdata = '0; av_be = '0; av_clken = 1'b1;
    st_start = 1'b0; st_base = '0; st_len = '0; mem_ready = 1'b1;
    test_reset();
    test_full_stream();
    test_byte_enable();
    test_read_old();
    test_wrap();
    test_backpressure();
    test_zero_len_and_busy();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
